// File: rtl/cfu_pkg.sv
// Shared types and constants for the control-flow unit.
//   XLEN               : address/data width
//   cfuop_t            : control-flow operation of the EX instruction
//   cfu_redir_state_t  : redirect sequencer states
//   INSTR_ALIGN_MASK   : target bits that must be zero for a legal fetch address
package cfu_pkg;

   localparam int XLEN = 32;

   typedef enum logic [3:0] {
      CFU_BEQ  = 4'd0,
      CFU_BNE  = 4'd1,
      CFU_BLT  = 4'd2,
      CFU_BGE  = 4'd3,
      CFU_BLTU = 4'd4,
      CFU_BGEU = 4'd5,
      CFU_JAL  = 4'd6,
      CFU_JALR = 4'd7
   } cfuop_t;

   typedef enum logic {
      CFR_IDLE = 1'b0,
      CFR_PEND = 1'b1
   } cfu_redir_state_t;

   localparam logic [1:0] INSTR_ALIGN_MASK = 2'b11;

endpackage

// File: rtl/cfu_perf_counter.sv
// Wrapping event counter with synchronous clear.
//   clk   : clock
//   clr   : synchronous clear, wins over en
//   en    : count one event this cycle
//   count : current value, wraps modulo 2^WIDTH
module cfu_perf_counter #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             en,
   output logic [WIDTH-1:0] count
);

   always_ff @(posedge clk) begin
      if (clr) begin
         count <= '0;
      end else if (en) begin
         count <= count + WIDTH'(1);
      end
   end

endmodule

// File: rtl/cfu_redirect_ctrl.sv
// Turns taken branch/jump resolutions in EX into a redirect handshake with
// fetch, flushes the wrong-path IF/ID and ID/EX contents, flags misaligned
// targets and counts resolved / redirected control-flow instructions.
//   clk, rst            : clock, synchronous active-high reset
//   ex_*_i              : EX-stage instruction and CFU resolution
//   redirect_valid_o/_ready_i/_pc_o : redirect handshake with fetch
//   flush_ifid_o, flush_idex_o      : clear pipeline registers this cycle
//   misalign_o          : taken target not instruction aligned (no redirect)
//   cf_count_o, taken_count_o       : performance counters
//
// state    | meaning
// CFR_IDLE | no redirect outstanding; EX resolutions are evaluated
// CFR_PEND | redirect to pend_pc waiting for fetch to accept it
module cfu_redirect_ctrl
   import cfu_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic            ex_valid_i,
   input  logic            ex_stall_i,
   input  logic            ex_cf_i,
   input  cfuop_t          ex_cfuop_i,
   input  logic            ex_br_taken_i,
   input  logic [XLEN-1:0] ex_target_i,
   output logic            redirect_valid_o,
   input  logic            redirect_ready_i,
   output logic [XLEN-1:0] redirect_pc_o,
   output logic            flush_ifid_o,
   output logic            flush_idex_o,
   output logic            misalign_o,
   output logic [31:0]     cf_count_o,
   output logic [31:0]     taken_count_o
);

   cfu_redir_state_t state;
   logic [XLEN-1:0]  pend_pc;
   logic [XLEN-1:0]  eff_target;
   logic             in_pend;
   logic             fire;
   logic             eval;
   logic             is_jump;
   logic             taken;
   logic             misaligned;
   logic             redirect_now;

   assign in_pend = (state == CFR_PEND);
   assign fire    = ex_valid_i & ~ex_stall_i;
   // ID/EX is held flushed while pending, so anything firing then is wrong-path.
   assign eval    = fire & ~in_pend;
   assign is_jump = (ex_cfuop_i == CFU_JAL) | (ex_cfuop_i == CFU_JALR);
   assign taken   = eval & ex_cf_i & (is_jump | ex_br_taken_i);

   assign eff_target   = (ex_cfuop_i == CFU_JALR) ? {ex_target_i[XLEN-1:1], 1'b0}
                                                  : ex_target_i;
   assign misaligned   = taken & ((eff_target[1:0] & INSTR_ALIGN_MASK) != 2'b00);
   assign redirect_now = taken & ~misaligned;

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= CFR_IDLE;
         pend_pc <= '0;
      end else begin
         case (state)
            CFR_IDLE: begin
               if (redirect_now && !redirect_ready_i) begin
                  state   <= CFR_PEND;
                  pend_pc <= eff_target;
               end
            end
            CFR_PEND: begin
               if (redirect_ready_i) begin
                  state <= CFR_IDLE;
               end
            end
            default: state <= CFR_IDLE;
         endcase
      end
   end

   // Zero-latency request: outputs are combinational from the fire cycle on.
   always_comb begin
      redirect_valid_o = 1'b0;
      redirect_pc_o    = '0;
      flush_ifid_o     = 1'b0;
      flush_idex_o     = 1'b0;
      misalign_o       = 1'b0;
      if (in_pend) begin
         redirect_valid_o = 1'b1;
         redirect_pc_o    = pend_pc;
         flush_ifid_o     = 1'b1;
         flush_idex_o     = 1'b1;
      end else if (taken) begin
         flush_ifid_o = 1'b1;
         flush_idex_o = 1'b1;
         if (misaligned) begin
            misalign_o = 1'b1;
         end else begin
            redirect_valid_o = 1'b1;
            redirect_pc_o    = eff_target;
         end
      end
   end

   cfu_perf_counter #(.WIDTH(32)) u_cf_count (
      .clk   (clk),
      .clr   (rst),
      .en    (eval & ex_cf_i),
      .count (cf_count_o)
   );

   cfu_perf_counter #(.WIDTH(32)) u_taken_count (
      .clk   (clk),
      .clr   (rst),
      .en    (redirect_now),
      .count (taken_count_o)
   );

endmodule

// File: tb/tb_cfu_redirect_ctrl.sv
module tb_cfu_redirect_ctrl;
   import cfu_pkg::*;

   logic        clk;
   logic        rst;
   logic        ex_valid_i;
   logic        ex_stall_i;
   logic        ex_cf_i;
   cfuop_t      ex_cfuop_i;
   logic        ex_br_taken_i;
   logic [31:0] ex_target_i;
   logic        redirect_valid_o;
   logic        redirect_ready_i;
   logic [31:0] redirect_pc_o;
   logic        flush_ifid_o;
   logic        flush_idex_o;
   logic        misalign_o;
   logic [31:0] cf_count_o;
   logic [31:0] taken_count_o;

   cfu_redirect_ctrl dut (
      .clk              (clk),
      .rst              (rst),
      .ex_valid_i       (ex_valid_i),
      .ex_stall_i       (ex_stall_i),
      .ex_cf_i          (ex_cf_i),
      .ex_cfuop_i       (ex_cfuop_i),
      .ex_br_taken_i    (ex_br_taken_i),
      .ex_target_i      (ex_target_i),
      .redirect_valid_o (redirect_valid_o),
      .redirect_ready_i (redirect_ready_i),
      .redirect_pc_o    (redirect_pc_o),
      .flush_ifid_o     (flush_ifid_o),
      .flush_idex_o     (flush_idex_o),
      .misalign_o       (misalign_o),
      .cf_count_o       (cf_count_o),
      .taken_count_o    (taken_count_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // reference model: an outstanding-redirect flag plus plain event counts
   bit          m_pend;
   logic [31:0] m_ppc;
   logic [31:0] m_cf;
   logic [31:0] m_tk;

   // values sampled from the DUT in the last step
   logic        a_rv, a_fl, a_mis;
   logic [31:0] a_pc, a_cf, a_tk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   // One clock cycle: drive at posedge+1, compare at negedge, advance model at posedge.
   task automatic step(input logic v, input logic s, input logic cf, input cfuop_t op,
                       input logic bt, input logic [31:0] tgt, input logic rdy,
                       input logic rs, input string tag);
      logic [31:0] eff, e_pc;
      logic        fire, tk, e_rv, e_fl, e_mis;
      ex_valid_i       = v;
      ex_stall_i       = s;
      ex_cf_i          = cf;
      ex_cfuop_i       = op;
      ex_br_taken_i    = bt;
      ex_target_i      = tgt;
      redirect_ready_i = rdy;
      rst              = rs;
      assert (!(m_pend && v && !s)) else $error("protocol: EX fired while redirect outstanding");
      fire  = v && !s;
      eff   = (op == CFU_JALR) ? (tgt & ~32'd1) : tgt;
      tk    = fire && !m_pend && cf && (op == CFU_JAL || op == CFU_JALR || bt);
      e_rv  = 1'b0;
      e_pc  = 32'd0;
      e_fl  = 1'b0;
      e_mis = 1'b0;
      if (m_pend) begin
         e_rv = 1'b1;
         e_pc = m_ppc;
         e_fl = 1'b1;
      end else if (tk) begin
         e_fl = 1'b1;
         if (eff % 4 != 0) e_mis = 1'b1;
         else begin
            e_rv = 1'b1;
            e_pc = eff;
         end
      end
      @(negedge clk);
      a_rv  = redirect_valid_o;
      a_pc  = redirect_pc_o;
      a_fl  = flush_ifid_o;
      a_mis = misalign_o;
      a_cf  = cf_count_o;
      a_tk  = taken_count_o;
      chk({tag, "/valid"}, 32'(a_rv), 32'(e_rv));
      chk({tag, "/pc"}, a_pc, e_pc);
      chk({tag, "/flush_ifid"}, 32'(flush_ifid_o), 32'(e_fl));
      chk({tag, "/flush_idex"}, 32'(flush_idex_o), 32'(e_fl));
      chk({tag, "/misalign"}, 32'(a_mis), 32'(e_mis));
      chk({tag, "/cf_count"}, a_cf, m_cf);
      chk({tag, "/taken_count"}, a_tk, m_tk);
      @(posedge clk);
      if (rs) begin
         m_pend = 1'b0;
         m_ppc  = 32'd0;
         m_cf   = 32'd0;
         m_tk   = 32'd0;
      end else if (m_pend) begin
         if (rdy) m_pend = 1'b0;
      end else begin
         if (fire && cf) m_cf = m_cf + 32'd1;
         if (e_rv) begin
            m_tk = m_tk + 32'd1;
            if (!rdy) begin
               m_pend = 1'b1;
               m_ppc  = eff;
            end
         end
      end
      #1;
   endtask

   task automatic idle(input logic rdy, input string tag);
      step(1'b0, 1'b0, 1'b0, CFU_BEQ, 1'b0, 32'd0, rdy, 1'b0, tag);
   endtask

   typedef struct {
      logic        v, s, cf;
      cfuop_t      op;
      logic        bt;
      logic [31:0] tgt;
      logic        rv;
      logic [31:0] pc;
      logic        fl;
      logic        mis;
   } vec_t;

   vec_t tbl[10];

   initial begin
      //          v     s     cf    op        bt    target        rv    pc            fl    mis
      tbl[0] = '{1'b1, 1'b0, 1'b1, CFU_BEQ,  1'b1, 32'h0000_0100, 1'b1, 32'h0000_0100, 1'b1, 1'b0};
      tbl[1] = '{1'b1, 1'b0, 1'b1, CFU_BNE,  1'b0, 32'h0000_0200, 1'b0, 32'h0000_0000, 1'b0, 1'b0};
      tbl[2] = '{1'b1, 1'b0, 1'b1, CFU_JAL,  1'b0, 32'h0000_0102, 1'b0, 32'h0000_0000, 1'b1, 1'b1};
      tbl[3] = '{1'b1, 1'b0, 1'b1, CFU_JALR, 1'b0, 32'h0000_2001, 1'b1, 32'h0000_2000, 1'b1, 1'b0};
      tbl[4] = '{1'b1, 1'b0, 1'b1, CFU_JALR, 1'b1, 32'h0000_2003, 1'b0, 32'h0000_0000, 1'b1, 1'b1};
      tbl[5] = '{1'b1, 1'b1, 1'b1, CFU_BEQ,  1'b1, 32'h0000_0400, 1'b0, 32'h0000_0000, 1'b0, 1'b0};
      tbl[6] = '{1'b1, 1'b0, 1'b0, CFU_JAL,  1'b1, 32'h0000_0500, 1'b0, 32'h0000_0000, 1'b0, 1'b0};
      tbl[7] = '{1'b1, 1'b0, 1'b1, CFU_BLT,  1'b1, 32'hFFFF_FFFC, 1'b1, 32'hFFFF_FFFC, 1'b1, 1'b0};
      tbl[8] = '{1'b1, 1'b0, 1'b1, CFU_JAL,  1'b0, 32'h0000_0040, 1'b1, 32'h0000_0040, 1'b1, 1'b0};
      tbl[9] = '{1'b0, 1'b0, 1'b1, CFU_BGE,  1'b1, 32'h0000_0080, 1'b0, 32'h0000_0000, 1'b0, 1'b0};

      m_pend = 1'b0;
      m_ppc  = 32'd0;
      m_cf   = 32'd0;
      m_tk   = 32'd0;
      ex_valid_i = 1'b0; ex_stall_i = 1'b0; ex_cf_i = 1'b0; ex_cfuop_i = CFU_BEQ;
      ex_br_taken_i = 1'b0; ex_target_i = 32'd0; redirect_ready_i = 1'b0;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      // reset state
      idle(1'b1, "reset");
      chk("reset_cf", a_cf, 32'd0);
      chk("reset_tk", a_tk, 32'd0);
      chk("reset_pc", a_pc, 32'd0);

      // single-cycle vectors, fetch always ready
      for (int i = 0; i < 10; i++) begin
         step(tbl[i].v, tbl[i].s, tbl[i].cf, tbl[i].op, tbl[i].bt, tbl[i].tgt,
              1'b1, 1'b0, $sformatf("vec%0d", i));
         chk($sformatf("vec%0d_rv", i), 32'(a_rv), 32'(tbl[i].rv));
         chk($sformatf("vec%0d_pc", i), a_pc, tbl[i].pc);
         chk($sformatf("vec%0d_fl", i), 32'(a_fl), 32'(tbl[i].fl));
         chk($sformatf("vec%0d_mis", i), 32'(a_mis), 32'(tbl[i].mis));
      end
      idle(1'b1, "post_tbl");
      chk("tbl_cf_count", a_cf, 32'd7);
      chk("tbl_taken_count", a_tk, 32'd4);

      // JALR held by busy fetch for three cycles
      step(1'b1, 1'b0, 1'b1, CFU_JALR, 1'b0, 32'h0000_2001, 1'b0, 1'b0, "jalr_fire");
      chk("jalr_hold0", a_pc, 32'h0000_2000);
      for (int i = 0; i < 3; i++) begin
         idle((i == 2) ? 1'b1 : 1'b0, "jalr_pend");
         chk($sformatf("jalr_hold%0d_rv", i + 1), 32'(a_rv), 32'd1);
         chk($sformatf("jalr_hold%0d_pc", i + 1), a_pc, 32'h0000_2000);
         chk($sformatf("jalr_hold%0d_fl", i + 1), 32'(a_fl), 32'd1);
      end
      idle(1'b0, "jalr_done");
      chk("jalr_done_rv", 32'(a_rv), 32'd0);
      chk("jalr_done_fl", 32'(a_fl), 32'd0);
      chk("jalr_taken_once", a_tk, 32'd5);

      // taken branch stalled two cycles
      for (int i = 0; i < 2; i++) begin
         step(1'b1, 1'b1, 1'b1, CFU_BEQ, 1'b1, 32'h0000_0300, 1'b1, 1'b0, "stall");
         chk($sformatf("stall%0d_rv", i), 32'(a_rv), 32'd0);
      end
      step(1'b1, 1'b0, 1'b1, CFU_BEQ, 1'b1, 32'h0000_0300, 1'b1, 1'b0, "stall_go");
      chk("stall_go_pc", a_pc, 32'h0000_0300);
      idle(1'b1, "stall_after");
      chk("stall_cf", a_cf, 32'd9);
      chk("stall_tk", a_tk, 32'd6);

      // reset while a redirect is pending
      step(1'b1, 1'b0, 1'b1, CFU_BGE, 1'b1, 32'h0000_0500, 1'b0, 1'b0, "rstp_fire");
      step(1'b0, 1'b0, 1'b0, CFU_BEQ, 1'b0, 32'd0, 1'b0, 1'b1, "rstp_rst");
      idle(1'b0, "rstp_after");
      chk("rstp_rv", 32'(a_rv), 32'd0);
      chk("rstp_cf", a_cf, 32'd0);
      chk("rstp_tk", a_tk, 32'd0);
      step(1'b1, 1'b0, 1'b1, CFU_BEQ, 1'b1, 32'h0000_0600, 1'b1, 1'b0, "rstp_redir");
      chk("rstp_redir_pc", a_pc, 32'h0000_0600);
      idle(1'b1, "rstp_redir_after");
      chk("rstp_redir_tk", a_tk, 32'd1);

      // randomized traffic against the model
      for (int i = 0; i < 400; i++) begin
         logic        v, s, cf, bt, rdy, rs;
         cfuop_t      op;
         logic [31:0] tgt;
         v   = m_pend ? 1'b0 : 1'($urandom_range(0, 1));
         s   = ($urandom_range(0, 3) == 0);
         cf  = ($urandom_range(0, 4) != 0);
         bt  = 1'($urandom_range(0, 1));
         op  = cfuop_t'($urandom_range(0, 7));
         tgt = $urandom;
         if ($urandom_range(0, 2) != 0) tgt[1:0] = 2'b00;
         rdy = 1'($urandom_range(0, 1));
         rs  = ($urandom_range(0, 60) == 0);
         step(v, s, cf, op, bt, tgt, rdy, rs, "rand");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/cfu_redirect_ctrl.md
# cfu_redirect_ctrl

Sequences program-counter redirection after the control-flow unit resolves a branch or jump in EX. It converts each taken resolution into a redirect handshake with the fetch stage and flushes the wrong-path instructions in IF/ID and ID/EX. It holds the redirect while fetch is busy, flags misaligned targets, and keeps control-flow performance counters. Static not-taken prediction is used, so every taken branch and every jump costs a redirect.

## Interface
- XLEN, 32, address/data width
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- ex_valid_i  in  1  EX stage holds a valid instruction
- ex_stall_i  in  1  EX is stalled this cycle; fire = ex_valid_i & !ex_stall_i
- ex_cf_i  in  1  EX instruction is BRANCH/JAL/JALR
- ex_cfuop_i  in  4  cfu_pkg::cfuop_t of EX instruction
- ex_br_taken_i  in  1  CFU compare result (branches only)
- ex_target_i  in  XLEN  raw target (pc+imm or rs1+imm)
- redirect_valid_o  out  1  redirect request to fetch
- redirect_ready_i  in  1  fetch accepts redirect this cycle
- redirect_pc_o  out  XLEN  redirect target
- flush_ifid_o  out  1  clear IF/ID at end of cycle
- flush_idex_o  out  1  clear ID/EX at end of cycle
- misalign_o  out  1  one-cycle pulse: taken target not 4-byte aligned
- cf_count_o  out  32  resolved control-flow instructions
- taken_count_o  out  32  redirects issued

## Operation
- taken = fire & ex_cf_i & (ex_cfuop_i ∈ {JAL, JALR} | ex_br_taken_i); JAL/JALR ignore ex_br_taken_i.
- Effective target: ex_target_i with bit 0 cleared for JALR; unchanged otherwise.
- misaligned = taken & (effective target bits[1:0] != 0). Asserts misalign_o and both flushes, with no redirect and no taken_count increment. Trap entry is handled elsewhere.
- FSM states are IDLE and PEND.
  - IDLE, taken & aligned: redirect_valid_o=1, redirect_pc_o=effective target, both flushes=1, all combinationally in the same cycle. If redirect_ready_i is high, stay in IDLE; otherwise latch the target into pend_pc and go to PEND.
  - PEND: redirect_valid_o=1, redirect_pc_o=pend_pc (stable), both flushes=1 every cycle. On redirect_ready_i go to IDLE.
  - A fire in PEND is a protocol violation because ID/EX is flushed. It is ignored (no counting, no redirect), and a bench assertion flags it.
- Counters:
  - cf_count_o increments on fire & ex_cf_i, including misaligned cases.
  - taken_count_o increments when a redirect is first requested (IDLE, taken & aligned), exactly once per redirect.
  - Both counters wrap modulo 2^32.
- Not-taken branch: no redirect and no flush; cf_count_o only.
- ex_stall_i high: nothing is evaluated, even if ex_valid_i=1.

## Timing
- Reset values: state=IDLE, pend_pc=0, cf_count_o=0, taken_count_o=0. With no fire, every combinational output is 0, and redirect_pc_o=0.
- Redirect latency is 0 cycles: the request appears in the fire cycle. It completes in the first cycle with valid & ready.
- Flushes are asserted in the fire cycle and every PEND cycle. They deassert in the cycle after acceptance.
- Counters are registered: they are visible on the cycle after the fire.
- rst asserted in PEND: next cycle is IDLE, redirect_valid_o=0, the pending redirect is dropped, and counters are zeroed.
- rst takes priority over fire in the same cycle.

## Structure
- cfu_pkg:
  - reuses cfuop_t
  - adds typedef enum logic {CFR_IDLE, CFR_PEND} cfu_redir_state_t
  - adds localparam INSTR_ALIGN_MASK = 2'b11
- One sub-module, cfu_perf_counter (32-bit wrapping counter with synchronous clear and enable), instantiated twice.
- The top holds the FSM, pend_pc register and output muxing.

## Test plan
- BEQ fire, ex_br_taken_i=1, ex_target_i=0x0000_0100, redirect_ready_i=1 -> same cycle: redirect_valid_o=1, redirect_pc_o=0x100, both flushes=1. Next cycle: taken_count_o=1, cf_count_o=1, state IDLE.
- BNE fire, ex_br_taken_i=0 -> no redirect, no flush; cf_count_o=1, taken_count_o=0.
- JALR fire, ex_br_taken_i=0, ex_target_i=0x0000_2001, redirect_ready_i low for 3 cycles -> redirect_pc_o=0x2000 held for 4 cycles, flushes high for 4 cycles, taken_count_o=1 (not 4). Deasserts after acceptance.
- JAL fire, ex_target_i=0x0000_0102 -> misalign_o pulse, both flushes=1, redirect_valid_o=0; cf_count_o=1, taken_count_o=0.
- Taken branch with ex_stall_i=1 for 2 cycles, then 0 -> redirect and count only in the third cycle.
- Redirect pending in PEND, rst asserted for 1 cycle -> redirect_valid_o=0 and counters=0 next cycle. A taken branch after reset redirects normally.
